// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the multiplexed display scanner:
//   - default separator / blank codes
//   - code-priority result encoding (BLINK_OFF > SEP > LZ > DATA)
//   - clog2 constant function, digit-select polarity helper, priority classifier
// -----------------------------------------------------------------------------
package disp_pkg;

    localparam logic [3:0] DEF_SEP_CODE   = 4'hB;
    localparam logic [3:0] DEF_BLANK_CODE = 4'hF;

    // Outcome of the per-digit priority resolution.
    typedef logic [1:0] res_t;
    localparam res_t RES_BLINK_OFF = 2'd0;
    localparam res_t RES_SEP       = 2'd1;
    localparam res_t RES_LZ        = 2'd2;
    localparam res_t RES_DATA      = 2'd3;

    // Ceiling log2, never less than 1 so that counters always have a bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Electrical level of one select line for a given logical state.
    function automatic logic sel_level(input logic active_low, input logic asserted);
        return asserted ^ active_low;
    endfunction

    // Highest-priority condition wins.
    function automatic res_t classify(input logic blink_off, input logic sep, input logic lz);
        if (blink_off) return RES_BLINK_OFF;
        if (sep)       return RES_SEP;
        if (lz)        return RES_LZ;
        return RES_DATA;
    endfunction

endpackage

// File: rtl/disp_scan_mux_if.sv
// -----------------------------------------------------------------------------
// disp_scan_mux_if
// Bundles the scanner's data/control inputs and its display-side outputs.
//   master : drives data_in, load, sep_mask, lz_blank_en, blink_mask,
//            blink_tick, brightness; observes digit_sel, digit_code,
//            digit_idx, frame_start
//   slave  : the scanner's view (directions reversed)
// -----------------------------------------------------------------------------
interface disp_scan_mux_if
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int NIB_W      = 4,
    parameter int PWM_BITS   = 4
);
    localparam int IDX_W = clog2(NUM_DIGITS);

    logic [NUM_DIGITS*NIB_W-1:0] data_in;
    logic                        load;
    logic [NUM_DIGITS-1:0]       sep_mask;
    logic                        lz_blank_en;
    logic [NUM_DIGITS-1:0]       blink_mask;
    logic                        blink_tick;
    logic [PWM_BITS-1:0]         brightness;

    logic [NUM_DIGITS-1:0]       digit_sel;
    logic [NIB_W-1:0]            digit_code;
    logic [IDX_W-1:0]            digit_idx;
    logic                        frame_start;

    modport master (
        output data_in, load, sep_mask, lz_blank_en, blink_mask, blink_tick, brightness,
        input  digit_sel, digit_code, digit_idx, frame_start
    );

    modport slave (
        input  data_in, load, sep_mask, lz_blank_en, blink_mask, blink_tick, brightness,
        output digit_sel, digit_code, digit_idx, frame_start
    );

endinterface

// File: rtl/disp_pwm_gen.sv
// -----------------------------------------------------------------------------
// disp_pwm_gen
// Timing base for the scanner: slot prescaler, slot index and free-running
// PWM counter.
//   clk, rst_n   : clock, asynchronous active-low reset
//   idx          : current slot index (0..NUM_DIGITS-1)
//   slot_first   : prescaler == 0 (first cycle of a slot, used as dead cycle)
//   pwm_cnt      : free-running PWM_BITS counter
//   wrap         : combinational, high in the cycle whose edge returns idx to 0
//   frame_pulse  : registered wrap, high while idx==0/prescaler==0 after a
//                  real wrap (never for the first frame after reset)
// -----------------------------------------------------------------------------
module disp_pwm_gen
    import disp_pkg::*;
#(
    parameter int  NUM_DIGITS = 8,
    parameter int  SCAN_DIV   = 1000,
    parameter int  PWM_BITS   = 4,
    localparam int IDX_W      = clog2(NUM_DIGITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [IDX_W-1:0]    idx,
    output logic                slot_first,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                wrap,
    output logic                frame_pulse
);

    localparam int               PRE_W    = clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]    prescaler_reg, prescaler_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [PWM_BITS-1:0] pwm_cnt_reg, pwm_cnt_next;
    logic                frame_pulse_reg;
    logic                tc;

    always_comb begin
        tc             = (prescaler_reg == PRE_LAST);
        wrap           = tc && (idx_reg == IDX_LAST);
        prescaler_next = tc ? '0 : prescaler_reg + PRE_W'(1);
        idx_next       = idx_reg;
        if (tc) begin
            idx_next = wrap ? '0 : idx_reg + IDX_W'(1);
        end
        pwm_cnt_next   = pwm_cnt_reg + PWM_BITS'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_reg   <= '0;
            idx_reg         <= '0;
            pwm_cnt_reg     <= '0;
            frame_pulse_reg <= 1'b0;
        end else begin
            prescaler_reg   <= prescaler_next;
            idx_reg         <= idx_next;
            pwm_cnt_reg     <= pwm_cnt_next;
            frame_pulse_reg <= wrap;
        end
    end

    assign idx         = idx_reg;
    assign slot_first  = (prescaler_reg == '0);
    assign pwm_cnt     = pwm_cnt_reg;
    assign frame_pulse = frame_pulse_reg;

endmodule

// File: rtl/disp_scan_mux.sv
// -----------------------------------------------------------------------------
// disp_scan_mux
// Time-multiplexed display scanner. Drives one digit per slot with a one-hot
// select and the matching nibble code for a downstream 7-segment decoder.
// Data is double-buffered (pending -> active at frame wrap) so a frame never
// mixes old and new values. Adds separators, leading-zero blanking, per-digit
// blink, PWM brightness and a dead cycle at the start of each slot.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : disp_scan_mux_if.slave
//                in : data_in, load, sep_mask, lz_blank_en, blink_mask,
//                     blink_tick, brightness
//                out: digit_sel, digit_code, digit_idx, frame_start
//                     (all registered, one cycle behind the slot counters)
// -----------------------------------------------------------------------------
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int               NUM_DIGITS     = 8,
    parameter int               NIB_W          = 4,
    parameter int               SCAN_DIV       = 1000,
    parameter int               PWM_BITS       = 4,
    parameter logic [NIB_W-1:0] SEP_CODE       = NIB_W'(DEF_SEP_CODE),
    parameter logic [NIB_W-1:0] BLANK_CODE     = NIB_W'(DEF_BLANK_CODE),
    parameter bit               SEL_ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    disp_scan_mux_if.slave  bus
);

    localparam int                    IDX_W    = clog2(NUM_DIGITS);
    localparam int                    DW       = NUM_DIGITS * NIB_W;
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE = {NUM_DIGITS{sel_level(SEL_ACTIVE_LOW, 1'b0)}};

    // Timing base
    logic [IDX_W-1:0]    idx;
    logic                slot_first;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                wrap;
    logic                frame_pulse;

    disp_pwm_gen #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .PWM_BITS   (PWM_BITS)
    ) u_pwm_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx         (idx),
        .slot_first  (slot_first),
        .pwm_cnt     (pwm_cnt),
        .wrap        (wrap),
        .frame_pulse (frame_pulse)
    );

    // Buffers and blink phase
    logic [DW-1:0] pending_reg;
    logic [DW-1:0] active_reg;
    logic          blink_phase_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg     <= '0;
            active_reg      <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            if (bus.load) begin
                pending_reg <= bus.data_in;
            end
            // A load landing on the wrap cycle bypasses pending so the new
            // value is already shown in the frame that is about to start.
            if (wrap) begin
                active_reg <= bus.load ? bus.data_in : pending_reg;
            end
            if (bus.blink_tick) begin
                blink_phase_reg <= ~blink_phase_reg;
            end
        end
    end

    // Per-digit resolution
    logic [NUM_DIGITS-1:0] is_zero;
    logic [NUM_DIGITS-1:0] zero_above;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [NUM_DIGITS-1:0] shown;
    logic [NIB_W-1:0]      code_arr [NUM_DIGITS];

    // zero_above[i]: every non-separator digit above i holds zero.
    // Separators are transparent to the leading-zero run.
    always_comb begin
        logic run;
        zero_above = '0;
        run        = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above[i] = run;
            if (!bus.sep_mask[i] && !is_zero[i]) begin
                run = 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [NIB_W-1:0] nib;
        res_t             res;

        assign nib         = active_reg[gi*NIB_W +: NIB_W];
        assign is_zero[gi] = (nib == '0);

        if (gi == 0) begin : g_lsd
            // The least significant digit always shows, even for a zero value.
            assign lz_blank[gi] = 1'b0;
        end else begin : g_upper
            assign lz_blank[gi] = bus.lz_blank_en & is_zero[gi] & zero_above[gi];
        end

        assign res = classify(blink_phase_reg & bus.blink_mask[gi],
                              bus.sep_mask[gi], lz_blank[gi]);

        assign code_arr[gi] = (res == RES_SEP)  ? SEP_CODE :
                              (res == RES_DATA) ? nib      : BLANK_CODE;
        assign shown[gi]    = (res == RES_SEP) || (res == RES_DATA);
    end

    // Output stage
    logic                  pwm_on;
    logic                  sel_on;
    logic [NIB_W-1:0]      code_next;
    logic [NUM_DIGITS-1:0] digit_sel_next;

    always_comb begin
        pwm_on    = (pwm_cnt < bus.brightness) || (&bus.brightness);
        // Prescaler 0 is a dead cycle so the previous digit's segments can
        // discharge before the next select line is driven.
        sel_on    = pwm_on && !slot_first && shown[idx];
        code_next = code_arr[idx];
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
        assign digit_sel_next[gi] = sel_level(SEL_ACTIVE_LOW, sel_on && (idx == IDX_W'(gi)));
    end

    logic [NUM_DIGITS-1:0] digit_sel_reg;
    logic [NIB_W-1:0]      digit_code_reg;
    logic [IDX_W-1:0]      digit_idx_reg;
    logic                  frame_start_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_sel_reg   <= SEL_IDLE;
            digit_code_reg  <= BLANK_CODE;
            digit_idx_reg   <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            digit_sel_reg   <= digit_sel_next;
            digit_code_reg  <= code_next;
            digit_idx_reg   <= idx;
            frame_start_reg <= frame_pulse;
        end
    end

    assign bus.digit_sel   = digit_sel_reg;
    assign bus.digit_code  = digit_code_reg;
    assign bus.digit_idx   = digit_idx_reg;
    assign bus.frame_start = frame_start_reg;

endmodule

// File: tb/tb_disp_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_disp_scan_mux
// Directed bench for disp_scan_mux with NUM_DIGITS=8, SCAN_DIV=4, PWM_BITS=4,
// active-low selects. A frame is 32 output cycles; output cycle c shows slot
// c/4 with prescaler c%4 (c%4 == 0 is the dead cycle). Outputs are sampled on
// the falling edge; inputs are changed on the falling edge.
// -----------------------------------------------------------------------------
module tb_disp_scan_mux;

    localparam int ND = 8;
    localparam int NW = 4;
    localparam int PB = 4;
    localparam int SD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    disp_scan_mux_if #(.NUM_DIGITS(ND), .NIB_W(NW), .PWM_BITS(PB)) bus ();

    disp_scan_mux #(
        .NUM_DIGITS     (ND),
        .NIB_W          (NW),
        .SCAN_DIV       (SD),
        .PWM_BITS       (PB),
        .SEP_CODE       (4'hB),
        .BLANK_CODE     (4'hF),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Checks one full frame starting at its frame_start cycle. exp_codes holds
    // the expected code per digit, exp_shown which digits get a select.
    // Optionally pulses load at output cycle load_at.
    task automatic check_frame(input string tag, input logic [31:0] exp_codes,
                               input logic [7:0] exp_shown, input int load_at,
                               input logic [31:0] load_val);
        logic [31:0] codes;
        codes = exp_codes;
        for (int c = 0; c < 32; c++) begin
            int          slot;
            logic [7:0]  esel;
            logic [3:0]  ecode;
            slot  = c / 4;
            esel  = ((c % 4) != 0 && exp_shown[slot]) ? ~(8'b1 << slot) : 8'hFF;
            ecode = codes[slot*4 +: 4];
            check({tag, "/idx"},  32'(bus.digit_idx),   32'(slot));
            check({tag, "/sel"},  32'(bus.digit_sel),   32'(esel));
            check({tag, "/code"}, 32'(bus.digit_code),  32'(ecode));
            check({tag, "/fs"},   32'(bus.frame_start), 32'(c == 0));
            bus.load = (c == load_at);
            if (c == load_at) bus.data_in = load_val;
            @(negedge clk);
        end
        bus.load = 1'b0;
        $display("frame %s: codes=%h shown=%b checks=%0d errors=%0d", tag, exp_codes, exp_shown, checks, errors);
    endtask

    // Called on a frame's first output cycle; returns on the next frame's first.
    task automatic settle();
        @(negedge clk);
        bus.load       = 1'b0;
        bus.blink_tick = 1'b0;
        repeat (31) @(negedge clk);
    endtask

    task automatic count_sel(input int cycles, output int n_on);
        n_on = 0;
        for (int c = 0; c < cycles; c++) begin
            check("onehot", 32'($countones(~bus.digit_sel) <= 1), 32'd1);
            if (bus.digit_sel != 8'hFF) n_on++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int n_on;

        bus.data_in     = '0;
        bus.load        = 1'b0;
        bus.sep_mask    = '0;
        bus.lz_blank_en = 1'b0;
        bus.blink_mask  = '0;
        bus.blink_tick  = 1'b1;     // must be ignored while in reset
        bus.brightness  = 4'hF;

        repeat (3) @(negedge clk);
        check("rst/sel",  32'(bus.digit_sel),   32'hFF);
        check("rst/code", 32'(bus.digit_code),  32'hF);
        check("rst/idx",  32'(bus.digit_idx),   32'd0);
        check("rst/fs",   32'(bus.frame_start), 32'd0);
        $display("step reset: checks=%0d errors=%0d", checks, errors);

        // Release and load the first value into the pending buffer.
        bus.blink_tick = 1'b0;
        rst_n          = 1'b1;
        bus.data_in    = 32'h1234_5678;
        bus.load       = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        n = 1;
        while (bus.frame_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        // No pulse in the first frame; first pulse 32 output cycles after it started.
        check("first_fs_cycle", 32'(n), 32'd33);

        // Plain scan: digits 7..0 show 1..8.
        check_frame("scan", 32'h1234_5678, 8'hFF, -1, 32'h0);
        // Mid-frame load at slot 3: current frame stays old.
        check_frame("tear_mid", 32'h1234_5678, 8'hFF, 13, 32'hAAAA_AAAA);
        // New data from the next frame; load coinciding with the wrap edge.
        check_frame("tear_new", 32'hAAAA_AAAA, 8'hFF, 30, 32'h8765_4321);
        check_frame("wrap_load", 32'h8765_4321, 8'hFF, -1, 32'h0);

        // Separators at digits 5 and 2 with leading-zero blanking.
        bus.data_in     = 32'h0000_0005;
        bus.load        = 1'b1;
        bus.sep_mask    = 8'b0010_0100;
        bus.lz_blank_en = 1'b1;
        settle();
        check_frame("sep_lz", 32'hFFBF_FBF5, 8'h25, -1, 32'h0);
        bus.data_in = 32'h0000_0000;
        bus.load    = 1'b1;
        settle();
        check_frame("sep_lz_zero", 32'hFFBF_FBF0, 8'h25, -1, 32'h0);

        // Blink digits 1 and 0.
        bus.sep_mask    = '0;
        bus.lz_blank_en = 1'b0;
        bus.data_in     = 32'h1234_5678;
        bus.load        = 1'b1;
        bus.blink_mask  = 8'h03;
        bus.blink_tick  = 1'b1;
        settle();
        check_frame("blink_off", 32'h1234_56FF, 8'hFC, -1, 32'h0);
        bus.blink_tick = 1'b1;
        settle();
        check_frame("blink_on", 32'h1234_5678, 8'hFF, -1, 32'h0);

        // PWM brightness 4: pwm_cnt and prescaler restart together and 4
        // divides 16, so on-counts 0..3 coincide with prescaler 0..3; the
        // prescaler-0 cycle is dead, leaving 3 lit cycles per 16.
        bus.blink_mask = '0;
        bus.brightness = 4'd4;
        settle();
        count_sel(16, n_on);
        check("pwm4/win0", 32'(n_on), 32'd3);
        count_sel(16, n_on);
        check("pwm4/win1", 32'(n_on), 32'd3);
        $display("step pwm4: checks=%0d errors=%0d", checks, errors);

        bus.brightness = 4'd0;
        count_sel(32, n_on);
        check("pwm0", 32'(n_on), 32'd0);
        $display("step pwm0: checks=%0d errors=%0d", checks, errors);

        // Asynchronous reset in the middle of slot 5.
        bus.brightness = 4'hF;
        repeat (22) @(negedge clk);
        check("pre_rst/idx", 32'(bus.digit_idx), 32'd5);
        check("pre_rst/sel", 32'(bus.digit_sel), 32'hDF);
        #2 rst_n = 1'b0;
        #1;
        check("arst/sel",  32'(bus.digit_sel),   32'hFF);
        check("arst/code", 32'(bus.digit_code),  32'hF);
        check("arst/idx",  32'(bus.digit_idx),   32'd0);
        check("arst/fs",   32'(bus.frame_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("resume/idx0",  32'(bus.digit_idx),  32'd0);
        check("resume/sel0",  32'(bus.digit_sel),  32'hFF);
        check("resume/code0", 32'(bus.digit_code), 32'h0);
        @(negedge clk);
        check("resume/sel1",  32'(bus.digit_sel),  32'hFE);
        repeat (3) @(negedge clk);
        check("resume/idx1",  32'(bus.digit_idx),  32'd1);
        n = 5;
        while (bus.frame_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("resume/first_fs", 32'(n), 32'd33);
        $display("step async_reset: checks=%0d errors=%0d", checks, errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
